// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default geometry, the zero word and default-sized address/word types.
package reg_file_pkg;

   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_NUM_REGS  = 8;
   localparam int DEF_ADDR_W    = $clog2(DEF_NUM_REGS);

   localparam logic [DEF_WORD_SIZE-1:0] ZERO_WORD = 16'h0000;

   typedef logic [DEF_WORD_SIZE-1:0] word_t;
   typedef logic [DEF_ADDR_W-1:0]    addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One registered read port of the register file.
// Selects the addressed word and busy bit, bypasses a same-cycle write,
// masks out-of-range addresses (and register 0 when REG_FILE_ZERO_REG_EN
// is defined), then registers the result. Data and busy hold while the
// port is idle; valid pulses for one cycle per accepted read.
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter  int WORD_SIZE = DEF_WORD_SIZE,
   parameter  int NUM_REGS  = DEF_NUM_REGS,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] i_mem [NUM_REGS],
   input  logic [NUM_REGS-1:0]  i_busy,
   input  logic                 i_wr_ok,
   input  logic [ADDR_W-1:0]    i_wr_addr,
   input  logic [WORD_SIZE-1:0] i_wr_data,
   input  logic                 i_rd_en,
   input  logic [ADDR_W-1:0]    i_rd_addr,
   output logic [WORD_SIZE-1:0] o_rd_data,
   output logic                 o_rd_valid,
   output logic                 o_rd_busy
);

   logic                 w_addr_ok;
   logic                 w_zero_hit;
   logic                 w_bypass;
   logic                 w_rd_go;
   logic [WORD_SIZE-1:0] w_sel_data;
   logic                 w_sel_busy;

   // Output stage starts at zero so nothing is X before the first reset.
   logic [WORD_SIZE-1:0] r_rd_data  = WORD_SIZE'(ZERO_WORD);
   logic                 r_rd_valid = 1'b0;
   logic                 r_rd_busy  = 1'b0;

   assign w_addr_ok = (32'(i_rd_addr) < NUM_REGS);
   assign w_bypass  = i_wr_ok && (i_wr_addr == i_rd_addr);
   assign w_rd_go   = (i_rd_en === 1'b1);

`ifdef REG_FILE_ZERO_REG_EN
   assign w_zero_hit = (i_rd_addr == {ADDR_W{1'b0}});
`else
   assign w_zero_hit = 1'b0;
`endif

   // Pick the word and busy bit this read would return; a same-cycle write
   // both supplies the data and has already cleared busy.
   always_comb begin
      w_sel_data = WORD_SIZE'(ZERO_WORD);
      w_sel_busy = 1'b0;
      if (!w_addr_ok || w_zero_hit) begin
         w_sel_data = WORD_SIZE'(ZERO_WORD);
         w_sel_busy = 1'b0;
      end else if (w_bypass) begin
         w_sel_data = i_wr_data;
         w_sel_busy = 1'b0;
      end else begin
         w_sel_data = i_mem[i_rd_addr];
         w_sel_busy = i_busy[i_rd_addr];
      end
   end

   // Register the read result; hold data/busy when idle, valid only on a read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data  <= WORD_SIZE'(ZERO_WORD);
         r_rd_busy  <= 1'b0;
         r_rd_valid <= 1'b0;
      end else if (w_rd_go) begin
         r_rd_data  <= w_sel_data;
         r_rd_busy  <= w_sel_busy;
         r_rd_valid <= 1'b1;
      end else begin
         r_rd_valid <= 1'b0;
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;
   assign o_rd_busy  = r_rd_busy;

endmodule : reg_file_read_port

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard.
// NUM_REGS words of WORD_SIZE bits, one synchronous write port, two
// registered read ports with write bypass. lock_en marks a register as
// awaiting writeback; a write clears it, and a same-cycle lock wins.
// Optional build macro REG_FILE_ZERO_REG_EN makes register 0 read as a
// constant zero that can be neither written nor locked.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter  int WORD_SIZE = DEF_WORD_SIZE,
   parameter  int NUM_REGS  = DEF_NUM_REGS,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic                 lock_en,
   input  logic [ADDR_W-1:0]    lock_addr,
   input  logic                 rd_en_a,
   input  logic [ADDR_W-1:0]    rd_addr_a,
   output logic [WORD_SIZE-1:0] rd_data_a,
   output logic                 rd_valid_a,
   output logic                 rd_busy_a,
   input  logic                 rd_en_b,
   input  logic [ADDR_W-1:0]    rd_addr_b,
   output logic [WORD_SIZE-1:0] rd_data_b,
   output logic                 rd_valid_b,
   output logic                 rd_busy_b
);

   // Storage and scoreboard start cleared so reads are defined before reset.
   logic [WORD_SIZE-1:0] r_mem [NUM_REGS] = '{default: WORD_SIZE'(ZERO_WORD)};
   logic [NUM_REGS-1:0]  r_busy = {NUM_REGS{1'b0}};

   logic w_wr_ok;
   logic w_lock_ok;

   // Strobes only count when exactly 1; out-of-range targets are dropped.
`ifdef REG_FILE_ZERO_REG_EN
   assign w_wr_ok   = (wr_en === 1'b1) && (32'(wr_addr) < NUM_REGS)
                      && (wr_addr != {ADDR_W{1'b0}});
   assign w_lock_ok = (lock_en === 1'b1) && (32'(lock_addr) < NUM_REGS)
                      && (lock_addr != {ADDR_W{1'b0}});
`else
   assign w_wr_ok   = (wr_en === 1'b1) && (32'(wr_addr) < NUM_REGS);
   assign w_lock_ok = (lock_en === 1'b1) && (32'(lock_addr) < NUM_REGS);
`endif

   // Storage array: cleared by reset, otherwise written by the write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= WORD_SIZE'(ZERO_WORD);
         end
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end else begin
         r_mem <= r_mem;
      end
   end

   // Busy scoreboard: write clears, lock sets; the lock is applied last so it
   // wins when both hit the same register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= {NUM_REGS{1'b0}};
      end else begin
         if (w_wr_ok) begin
            r_busy[wr_addr] <= 1'b0;
         end
         if (w_lock_ok) begin
            r_busy[lock_addr] <= 1'b1;
         end
      end
   end

   reg_file_read_port #(
      .WORD_SIZE (WORD_SIZE),
      .NUM_REGS  (NUM_REGS)
   ) u_port_a (
      .clk        (clk),
      .reset      (reset),
      .i_mem      (r_mem),
      .i_busy     (r_busy),
      .i_wr_ok    (w_wr_ok),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_rd_en    (rd_en_a),
      .i_rd_addr  (rd_addr_a),
      .o_rd_data  (rd_data_a),
      .o_rd_valid (rd_valid_a),
      .o_rd_busy  (rd_busy_a)
   );

   reg_file_read_port #(
      .WORD_SIZE (WORD_SIZE),
      .NUM_REGS  (NUM_REGS)
   ) u_port_b (
      .clk        (clk),
      .reset      (reset),
      .i_mem      (r_mem),
      .i_busy     (r_busy),
      .i_wr_ok    (w_wr_ok),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_rd_en    (rd_en_b),
      .i_rd_addr  (rd_addr_b),
      .o_rd_data  (rd_data_b),
      .o_rd_valid (rd_valid_b),
      .o_rd_busy  (rd_busy_b)
   );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default 8 x 16-bit).
// Follows REG_FILE_ZERO_REG_EN so the same bench covers both builds.
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic  clk;
   logic  reset;
   logic  wr_en;
   addr_t wr_addr;
   word_t wr_data;
   logic  lock_en;
   addr_t lock_addr;
   logic  rd_en_a;
   addr_t rd_addr_a;
   word_t rd_data_a;
   logic  rd_valid_a;
   logic  rd_busy_a;
   logic  rd_en_b;
   addr_t rd_addr_b;
   word_t rd_data_b;
   logic  rd_valid_b;
   logic  rd_busy_b;

   int n_cmp = 0;
   int n_bad = 0;

   reg_file_sb dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .lock_en    (lock_en),
      .lock_addr  (lock_addr),
      .rd_en_a    (rd_en_a),
      .rd_addr_a  (rd_addr_a),
      .rd_data_a  (rd_data_a),
      .rd_valid_a (rd_valid_a),
      .rd_busy_a  (rd_busy_a),
      .rd_en_b    (rd_en_b),
      .rd_addr_b  (rd_addr_b),
      .rd_data_b  (rd_data_b),
      .rd_valid_b (rd_valid_b),
      .rd_busy_b  (rd_busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset   = 1'b0;
      wr_en   = 1'b0;
      lock_en = 1'b0;
      rd_en_a = 1'b0;
      rd_en_b = 1'b0;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Check port A result (data, busy, valid).
   task automatic chk_a(input string tag, input logic [15:0] d, input logic bz, input logic v);
      chk16({tag, "_data_a"}, rd_data_a, d);
      chk1({tag, "_busy_a"}, rd_busy_a, bz);
      chk1({tag, "_valid_a"}, rd_valid_a, v);
   endtask

   // Check port B result (data, busy, valid).
   task automatic chk_b(input string tag, input logic [15:0] d, input logic bz, input logic v);
      chk16({tag, "_data_b"}, rd_data_b, d);
      chk1({tag, "_busy_b"}, rd_busy_b, bz);
      chk1({tag, "_valid_b"}, rd_valid_b, v);
   endtask

   initial begin
      idle();
      wr_addr   = 3'd0;
      wr_data   = 16'h0000;
      lock_addr = 3'd0;
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd0;

      // Power-up: outputs are zero before any reset.
      #1;
      chk_a("pwrup", 16'h0000, 1'b0, 1'b0);
      chk_b("pwrup", 16'h0000, 1'b0, 1'b0);

      // Reset.
      reset = 1'b1;
      tick();
      chk_a("reset", 16'h0000, 1'b0, 1'b0);
      chk_b("reset", 16'h0000, 1'b0, 1'b0);
      idle();

      // 1: every register reads zero/not busy on both ports.
      for (int r = 0; r < 8; r++) begin
         rd_en_a   = 1'b1;
         rd_addr_a = addr_t'(r);
         rd_en_b   = 1'b1;
         rd_addr_b = addr_t'(7 - r);
         tick();
         chk_a("t1", 16'h0000, 1'b0, 1'b1);
         chk_b("t1", 16'h0000, 1'b0, 1'b1);
      end
      idle();

      // 2: write r3, read it back, then hold.
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
      tick();
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd3;
      tick();
      chk_a("t2_rd", 16'hA5A5, 1'b0, 1'b1);
      idle();
      tick();
      chk_a("t2_hold", 16'hA5A5, 1'b0, 1'b0);

      // 3: same-cycle write/read bypass on both ports.
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
      rd_en_a = 1'b1; rd_addr_a = 3'd5;
      rd_en_b = 1'b1; rd_addr_b = 3'd5;
      tick();
      chk_a("t3_byp", 16'h1234, 1'b0, 1'b1);
      chk_b("t3_byp", 16'h1234, 1'b0, 1'b1);
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd5;
      tick();
      chk_a("t3_later", 16'h1234, 1'b0, 1'b1);
      chk1("t3_b_idle_valid", rd_valid_b, 1'b0);
      idle();

      // 4: scoreboard.
      lock_en = 1'b1; lock_addr = 3'd2;
      tick();
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd2;
      tick();
      chk_a("t4_locked", 16'h0000, 1'b1, 1'b1);
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0F0F;
      rd_en_a = 1'b1; rd_addr_a = 3'd2;
      tick();
      chk_a("t4_wrclr", 16'h0F0F, 1'b0, 1'b1);
      idle();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5A5A;
      lock_en = 1'b1; lock_addr = 3'd2;
      tick();
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd2;
      tick();
      chk_a("t4_lockwins", 16'h5A5A, 1'b1, 1'b1);
      idle();
      // Same-cycle lock is not visible to that read, only to the next one.
      lock_en = 1'b1; lock_addr = 3'd4;
      rd_en_b = 1'b1; rd_addr_b = 3'd4;
      tick();
      chk_b("t4_lock_same", 16'h0000, 1'b0, 1'b1);
      idle();
      rd_en_b = 1'b1; rd_addr_b = 3'd4;
      tick();
      chk_b("t4_lock_next", 16'h0000, 1'b1, 1'b1);
      idle();

      // X strobes are inactive.
      wr_en = 1'bx; wr_addr = 3'd1; wr_data = 16'hDEAD;
      lock_en = 1'bx; lock_addr = 3'd1;
      tick();
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd1;
      tick();
      chk_a("xstrobe", 16'h0000, 1'b0, 1'b1);
      idle();

      // 5: reset beats a same-cycle write and clears everything.
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hFFFF;
      tick();
      idle();
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1111;
      rd_en_a = 1'b1; rd_addr_a = 3'd6;
      tick();
      chk_a("t5_rst", 16'h0000, 1'b0, 1'b0);
      chk_b("t5_rst", 16'h0000, 1'b0, 1'b0);
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd6;
      rd_en_b = 1'b1; rd_addr_b = 3'd2;
      tick();
      chk_a("t5_r6", 16'h0000, 1'b0, 1'b1);
      chk_b("t5_r2", 16'h0000, 1'b0, 1'b1);
      idle();
      rd_en_b = 1'b1; rd_addr_b = 3'd4;
      tick();
      chk_b("t5_r4", 16'h0000, 1'b0, 1'b1);
      idle();

      // 6: register 0 behaviour depends on the build.
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF;
      rd_en_a = 1'b1; rd_addr_a = 3'd0;
      tick();
`ifdef REG_FILE_ZERO_REG_EN
      chk_a("t6_byp", 16'h0000, 1'b0, 1'b1);
`else
      chk_a("t6_byp", 16'hBEEF, 1'b0, 1'b1);
`endif
      idle();
      lock_en = 1'b1; lock_addr = 3'd0;
      tick();
      idle();
      rd_en_a = 1'b1; rd_addr_a = 3'd0;
      rd_en_b = 1'b1; rd_addr_b = 3'd0;
      tick();
`ifdef REG_FILE_ZERO_REG_EN
      chk_a("t6_r0", 16'h0000, 1'b0, 1'b1);
      chk_b("t6_r0", 16'h0000, 1'b0, 1'b1);
`else
      chk_a("t6_r0", 16'hBEEF, 1'b1, 1'b1);
      chk_b("t6_r0", 16'hBEEF, 1'b1, 1'b1);
`endif
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_reg_file_sb
